// File: rtl/cpu_io_bus_if.sv
// Core data-port bus between the MIPS core and the memory/I-O controller.
interface cpu_io_bus_if;
    logic [31:0] m_addr;
    logic        m_write;
    logic        m_read;
    logic [31:0] d_t_mem;
    logic [31:0] d_f_mem;

    modport master (
        output m_addr,
        output m_write,
        output m_read,
        output d_t_mem,
        input  d_f_mem
    );

    modport slave (
        input  m_addr,
        input  m_write,
        input  m_read,
        input  d_t_mem,
        output d_f_mem
    );
endinterface

// File: rtl/cpu_io_bus_ctrl.sv
// Memory/I-O bus controller: RAM vs I-O decode, combinational read mux,
// keyboard scan-code FIFO, prescaled tick timer and LED register.
module cpu_io_bus_ctrl #(
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned FIFO_AW  = 4,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                clrn,
    cpu_io_bus_if.slave         bus,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic                ram_we,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    input  logic                kbd_valid,
    input  logic [7:0]          kbd_code,
    output logic [15:0]         led,
    output logic                kbd_irq
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [2:0] SEL_STAT = 3'd0;
    localparam logic [2:0] SEL_DATA = 3'd1;
    localparam logic [2:0] SEL_TCNT = 3'd2;
    localparam logic [2:0] SEL_TCTL = 3'd3;
    localparam logic [2:0] SEL_LED  = 3'd4;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        timer_q, timer_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tmr_en_q, tmr_en_d;
    logic [15:0]        led_q, led_d;
    logic               irq_q, irq_d;

    logic               is_io;
    logic [2:0]         sel;
    logic               st_io;
    logic               ld_io;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               tick;
    logic [31:0]        stat_rd;
    logic [31:0]        head_rd;
    logic               unused_addr;

    // Address decode; a store beats a load if both strobes are high
    assign is_io = bus.m_addr[31];
    assign sel   = bus.m_addr[4:2];
    assign st_io = is_io & bus.m_write;
    assign ld_io = is_io & bus.m_read & ~bus.m_write;

    assign ram_addr  = bus.m_addr[RAM_AW+1:2];
    assign ram_we    = ~is_io & bus.m_write;
    assign ram_wdata = bus.d_t_mem;

    assign unused_addr = ^{bus.m_addr[30:RAM_AW+2], bus.m_addr[1:0]};

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = ld_io & (sel == SEL_DATA) & ~empty;
    assign push  = kbd_valid & (~full | pop);
    assign drop  = kbd_valid & full & ~pop;
    assign tick  = tmr_en_q & (presc_q == PRESC_MAX);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        timer_d  = timer_q;
        presc_d  = presc_q;
        tmr_en_d = tmr_en_q;
        led_d    = led_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Dropped byte sets ovf after the clear so a simultaneous set wins
        if (st_io && (sel == SEL_STAT) && bus.d_t_mem[1]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        if (st_io && (sel == SEL_TCNT)) begin
            timer_d = bus.d_t_mem;
            presc_d = '0;
        end else if (tmr_en_q) begin
            if (tick) begin
                presc_d = '0;
                timer_d = timer_q + 32'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (st_io && (sel == SEL_TCTL)) begin
            tmr_en_d = bus.d_t_mem[0];
        end
        if (st_io && (sel == SEL_LED)) begin
            led_d = bus.d_t_mem[15:0];
        end

        irq_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            timer_q  <= '0;
            presc_q  <= '0;
            tmr_en_q <= 1'b0;
            led_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            tmr_en_q <= tmr_en_d;
            led_q    <= led_d;
            irq_q    <= irq_d;
        end
    end

    // FIFO storage carries no reset; only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= kbd_code;
        end
    end

    always_comb begin
        stat_rd              = '0;
        stat_rd[8 +: CW]     = count_q;
        stat_rd[1]           = ovf_q;
        stat_rd[0]           = ~empty;
        head_rd              = empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr_q]};
    end

    // Core cannot stall, so read data is purely combinational
    always_comb begin
        bus.d_f_mem = 32'd0;
        if (!is_io) begin
            bus.d_f_mem = ram_rdata;
        end else begin
            case (sel)
                SEL_STAT: bus.d_f_mem = stat_rd;
                SEL_DATA: bus.d_f_mem = head_rd;
                SEL_TCNT: bus.d_f_mem = timer_q;
                SEL_TCTL: bus.d_f_mem = {31'd0, tmr_en_q};
                SEL_LED:  bus.d_f_mem = {16'd0, led_q};
                default:  bus.d_f_mem = 32'd0;
            endcase
        end
    end

    assign led     = led_q;
    assign kbd_irq = irq_q;

endmodule
